ward_call_decoder: RTL and testbench
====================================

# ward_call_decoder

Receiver/decoder side of the ward-call link. It accepts the 3-bit ward code produced by the ward priority encoder (0–3 = ward index, 4 = no call) and latches each call as a per-ward pending request. It drives the nurse-station lamps and buzzer, escalates calls left unacknowledged too long, and clears a request when the nurse acknowledges that ward.

## Interface
Parameters:
- BLINK_DIV, 4 — half-period, in clock cycles, of the shared blink phase; legal range ≥ 1.
- ESC_CYCLES, 16 — cycles a call may stay pending before escalation; legal range ≥ 1.

Ports:
- clk  in  1  — single clock, all state on rising edge.
- rst  in  1  — asynchronous, active-high reset.
- code_valid  in  1  — code is sampled on this edge.
- code  in  3  — 0–3 ward call, 4 no call, 5–7 illegal.
- ack  in  4  — per-ward acknowledge, level sampled each edge.
- pending  out  4  — latched call per ward.
- lamp  out  4  — station lamp per ward.
- buzzer  out  1  — station buzzer.
- escalate  out  1  — high while any ward is escalated.
- err  out  1  — one-cycle pulse on an illegal code.
- serve_idx  out  3  — present only with WARD_CALL_DECODER_SERVE_EN; see Configuration.

## Operation
- Per-ward state: pending[i], age[i] (saturating counter, width $clog2(ESC_CYCLES+1)), esc[i].
- Set rule: code_valid && code<4 sets pending[code].
  - If the ward was not already pending, age[code] clears to 0 and esc[code] clears.
  - A repeat call to an already-pending ward does not restart its age.
- code==4 with code_valid: no effect.
- code 5–7 with code_valid: no state change; err is high for exactly the following cycle.
- Clear rule: ack[i] clears pending[i], age[i] and esc[i].
  - Set and ack on the same ward in the same edge: the set wins. Pending stays 1 and age restarts at 0.
  - ack on a non-pending ward is ignored.
- Aging: while pending[i], age[i] increments each edge, saturating at ESC_CYCLES. esc[i] sets on the edge where age[i] reaches ESC_CYCLES.
- Blink: a free-running counter toggles blink_ph every BLINK_DIV edges. It runs from reset, not from call start.
- FSM (registered), evaluated from the current pending/esc registers:
  - IDLE when no ward is pending.
  - CALL when some ward is pending and none is escalated.
  - ALARM when any ward is escalated.
  - Transitions in any direction take effect on the next edge.
- Outputs (registered, updated together with the FSM):
  - lamp[i] = pending[i] && (!esc[i] || blink_ph).
  - buzzer: 0 in IDLE, 1 in CALL, blink_ph in ALARM.
  - escalate = (state==ALARM).

## Timing
- Reset: pending=0, age=0, esc=0, blink_ph=0, state=IDLE, lamp=0, buzzer=0, escalate=0, err=0, serve_idx=4.
- Reset asserted mid-operation discards all calls immediately. There is no memory of them after release.
- Call sampled at edge E:
  - pending visible after E.
  - lamp, buzzer and state visible after E+1.
- esc[i] rises ESC_CYCLES edges after the set edge. escalate and lamp blinking begin one edge later.
- ack at edge A: pending[i] drops after A; lamp[i] drops after A+1. If it was the last pending ward, the FSM returns to IDLE after A+1.
- err: the illegal code is sampled at edge E; err is high for exactly the cycle between E and E+1.

## Configuration
- WARD_CALL_DECODER_SERVE_EN defined: adds registered output serve_idx[2:0], the ward the nurse should attend next.
  - Escalated wards take precedence over non-escalated ones.
  - Within the same class, the lowest index wins.
  - Value is 4 when nothing is pending.
  - Updated with the same one-edge lag as lamp.
- WARD_CALL_DECODER_SERVE_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package ward_pkg holds:
  - NUM_WARDS=4
  - CODE_NONE=3'd4
  - the state typedef (IDLE, CALL, ALARM)
  - the code width constant
- Sub-module ward_slot owns pending, age and esc for one ward (inputs set, clr, plus parameter ESC_CYCLES). It is instantiated NUM_WARDS times. FSM, blink counter and output registers stay in the top module.

## Test plan
- Reset then code=2 valid at edge 1 → pending=0100 after edge 1; lamp=0100, buzzer=1, state CALL after edge 2.
- Leave ward 2 pending with ESC_CYCLES=16, BLINK_DIV=4 → esc after edge 17; escalate=1 after edge 18; lamp[2] and buzzer toggle every 4 cycles.
- Ward 1 pending; same edge code=1 valid and ack=0010 → pending[1] stays 1 and age restarts (escalation 16 edges later, not earlier).
- code=6 valid → err high for exactly one cycle; pending, lamp and state unchanged; code=4 valid → no effect and no err.
- Wards 0 and 3 called, ward 3 escalated first, ack ward 3 → state ALARM→CALL; with WARD_CALL_DECODER_SERVE_EN, serve_idx 3 then 0, then 4 after ack ward 0.
- Two calls pending, assert rst asynchronously mid-cycle → all outputs zero immediately, serve_idx=4; after release, no lamp without a new call.

Source files
------------

// File: rtl/ward_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ward_pkg
// Brief   : Shared constants and FSM state encoding for the ward-call decoder.
// Revision: 1.0 - initial release
// ============================================================================
package ward_pkg;

    localparam int NUM_WARDS = 4;
    localparam int CODE_W    = 3;

    localparam logic [CODE_W-1:0] CODE_NONE = 3'd4;

    typedef logic [1:0] ward_state_t;

    localparam ward_state_t IDLE  = 2'd0;
    localparam ward_state_t CALL  = 2'd1;
    localparam ward_state_t ALARM = 2'd2;

endpackage : ward_pkg
`default_nettype wire

// File: rtl/ward_slot.sv
`default_nettype none
// ============================================================================
// Module  : ward_slot
// Brief   : One ward's pending latch, saturating age counter and escalation flag.
// Revision: 1.0 - initial release
// ============================================================================
module ward_slot
    import ward_pkg::*;
#(
    parameter int ESC_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic pending,
    output logic esc
);

    localparam int                 c_age_w   = $clog2(ESC_CYCLES + 1);
    localparam logic [c_age_w-1:0] c_age_max = c_age_w'(ESC_CYCLES);

    logic [c_age_w-1:0] r_age;
    logic               r_pending;
    logic               r_esc;

    logic               w_restart;
    logic               w_clear;
    logic               w_tick;
    logic [c_age_w-1:0] w_age_inc;

    // A set restarts aging for a fresh call, and also when it collides with an ack.
    assign w_restart = set && (!r_pending || clr);
    assign w_clear   = r_pending && clr && !set;
    assign w_tick    = r_pending && !clr;
    assign w_age_inc = r_age + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_age     <= '0;
            r_esc     <= 1'b0;
        end else if (w_restart) begin
            r_pending <= 1'b1;
            r_age     <= '0;
            r_esc     <= 1'b0;
        end else if (w_clear) begin
            r_pending <= 1'b0;
            r_age     <= '0;
            r_esc     <= 1'b0;
        end else if (w_tick && (r_age != c_age_max)) begin
            r_age <= w_age_inc;
            if (w_age_inc == c_age_max) begin
                r_esc <= 1'b1;
            end
        end
    end

    assign pending = r_pending;
    assign esc     = r_esc;

endmodule : ward_slot
`default_nettype wire

// File: rtl/ward_call_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ward_call_decoder
// Brief   : Latches ward calls, drives lamps/buzzer, escalates stale calls.
//           Optional serve_idx output enabled by WARD_CALL_DECODER_SERVE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ward_call_decoder
    import ward_pkg::*;
#(
    parameter int BLINK_DIV  = 4,
    parameter int ESC_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 code_valid,
    input  logic [CODE_W-1:0]    code,
    input  logic [NUM_WARDS-1:0] ack,
    output logic [NUM_WARDS-1:0] pending,
    output logic [NUM_WARDS-1:0] lamp,
    output logic                 buzzer,
    output logic                 escalate,
    output logic                 err
`ifdef WARD_CALL_DECODER_SERVE_EN
    ,
    output logic [CODE_W-1:0]    serve_idx
`endif
);

    localparam int                   c_blink_w    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    logic [NUM_WARDS-1:0] w_set;
    logic [NUM_WARDS-1:0] w_esc;
    ward_state_t          w_state_nxt;

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_ph;
    ward_state_t          r_state;
    logic [NUM_WARDS-1:0] r_lamp;
    logic                 r_buzzer;
    logic                 r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARDS; gi++) begin : g_slot
            assign w_set[gi] = code_valid && (code == CODE_W'(gi));

            ward_slot #(
                .ESC_CYCLES (ESC_CYCLES)
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .set     (w_set[gi]),
                .clr     (ack[gi]),
                .pending (pending[gi]),
                .esc     (w_esc[gi])
            );
        end
    endgenerate

    // Blink phase is free-running from reset so all escalated lamps flash in step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (|w_esc) begin
            w_state_nxt = ALARM;
        end else if (|pending) begin
            w_state_nxt = CALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lamp   <= '0;
            r_buzzer <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lamp   <= pending & (~w_esc | {NUM_WARDS{r_blink_ph}});
            r_buzzer <= (w_state_nxt == CALL) || ((w_state_nxt == ALARM) && r_blink_ph);
            r_err    <= code_valid && (code > CODE_NONE);
        end
    end

    assign lamp     = r_lamp;
    assign buzzer   = r_buzzer;
    assign escalate = (r_state == ALARM);
    assign err      = r_err;

`ifdef WARD_CALL_DECODER_SERVE_EN
    logic [CODE_W-1:0] w_serve;
    logic [CODE_W-1:0] r_serve;

    // Scan downward so the lowest index is written last; escalated wards override.
    always_comb begin
        w_serve = CODE_NONE;
        for (int i = NUM_WARDS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                w_serve = CODE_W'(i);
            end
        end
        for (int i = NUM_WARDS - 1; i >= 0; i--) begin
            if (w_esc[i]) begin
                w_serve = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_serve <= CODE_NONE;
        end else begin
            r_serve <= w_serve;
        end
    end

    assign serve_idx = r_serve;
`endif

endmodule : ward_call_decoder
`default_nettype wire

// File: tb/tb_ward_call_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ward_call_decoder
// Brief   : Self-checking bench: vector table, corner sequences, random vs model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ward_call_decoder;

    localparam int BLINK_DIV  = 4;
    localparam int ESC_CYCLES = 16;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       code_valid = 1'b0;
    logic [2:0] code       = 3'd0;
    logic [3:0] ack        = 4'd0;
    logic [3:0] pending;
    logic [3:0] lamp;
    logic       buzzer;
    logic       escalate;
    logic       err;
`ifdef WARD_CALL_DECODER_SERVE_EN
    logic [2:0] serve_idx;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ward_call_decoder #(
        .BLINK_DIV  (BLINK_DIV),
        .ESC_CYCLES (ESC_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code       (code),
        .ack        (ack),
        .pending    (pending),
        .lamp       (lamp),
        .buzzer     (buzzer),
        .escalate   (escalate),
        .err        (err)
`ifdef WARD_CALL_DECODER_SERVE_EN
        ,
        .serve_idx  (serve_idx)
`endif
    );

    // Reference model: per-ward call records plus an edge count since reset.
    bit         m_pend [4];
    int         m_age  [4];
    bit         m_esc  [4];
    int         m_edges;
    logic [3:0] m_lamp;
    bit         m_buzz;
    bit         m_escal;
    bit         m_err;
    int         m_serve;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_age[i]  = 0;
            m_esc[i]  = 0;
        end
        m_edges = 0;
        m_lamp  = 4'd0;
        m_buzz  = 0;
        m_escal = 0;
        m_err   = 0;
        m_serve = 4;
    endtask

    task automatic model_edge(input bit v, input logic [2:0] c, input logic [3:0] a);
        bit blink;
        bit any_e;
        bit any_p;
        bit set;
        blink = ((m_edges / BLINK_DIV) % 2) == 1;
        any_e = 0;
        any_p = 0;
        for (int i = 0; i < 4; i++) begin
            any_e     = any_e | m_esc[i];
            any_p     = any_p | m_pend[i];
            m_lamp[i] = m_pend[i] && (!m_esc[i] || blink);
        end
        m_serve = 4;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) m_serve = i;
        for (int i = 3; i >= 0; i--) if (m_esc[i]) m_serve = i;
        m_buzz  = any_e ? blink : any_p;
        m_escal = any_e;
        m_err   = v && (c > 3'd4);
        for (int i = 0; i < 4; i++) begin
            set = v && (int'(c) == i);
            if (set) begin
                if (!m_pend[i] || a[i]) begin
                    m_age[i] = 0;
                    m_esc[i] = 0;
                end else begin
                    if (m_age[i] < ESC_CYCLES) m_age[i]++;
                    if (m_age[i] == ESC_CYCLES) m_esc[i] = 1;
                end
                m_pend[i] = 1;
            end else if (m_pend[i]) begin
                if (a[i]) begin
                    m_pend[i] = 0;
                    m_age[i]  = 0;
                    m_esc[i]  = 0;
                end else begin
                    if (m_age[i] < ESC_CYCLES) m_age[i]++;
                    if (m_age[i] == ESC_CYCLES) m_esc[i] = 1;
                end
            end
        end
        m_edges++;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = m_pend[i];
        chk({tag, ".pending"}, int'(pending), int'(p));
        chk({tag, ".lamp"}, int'(lamp), int'(m_lamp));
        chk({tag, ".buzzer"}, int'(buzzer), int'(m_buzz));
        chk({tag, ".escalate"}, int'(escalate), int'(m_escal));
        chk({tag, ".err"}, int'(err), int'(m_err));
`ifdef WARD_CALL_DECODER_SERVE_EN
        chk({tag, ".serve_idx"}, int'(serve_idx), m_serve);
`endif
    endtask

    task automatic step(input bit v, input logic [2:0] c, input logic [3:0] a);
        code_valid = v;
        code       = c;
        ack        = a;
        @(posedge clk);
        model_edge(v, c, a);
        @(negedge clk);
        code_valid = 1'b0;
        code       = 3'd0;
        ack        = 4'd0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".pending"}, int'(pending), 0);
        chk({tag, ".lamp"}, int'(lamp), 0);
        chk({tag, ".buzzer"}, int'(buzzer), 0);
        chk({tag, ".escalate"}, int'(escalate), 0);
        chk({tag, ".err"}, int'(err), 0);
`ifdef WARD_CALL_DECODER_SERVE_EN
        chk({tag, ".serve_idx"}, int'(serve_idx), 4);
`endif
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        code_valid = 1'b0;
        code       = 3'd0;
        ack        = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         v;
        logic [2:0] c;
        logic [3:0] a;
        logic [3:0] p;
        logic [3:0] l;
        bit         b;
        bit         e;
        bit         r;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // {valid, code, ack, exp pending, exp lamp, exp buzzer, exp escalate, exp err}
        tbl[0]  = '{1'b1, 3'd2, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 4'h0, 4'h4, 4'h4, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd6, 4'h0, 4'h4, 4'h4, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 3'd4, 4'h0, 4'h4, 4'h4, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'd0, 4'h4, 4'h1, 4'h4, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'd7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 3'd5, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 3'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].v, tbl[k].c, tbl[k].a);
            chk($sformatf("tbl%0d.pending", k), int'(pending), int'(tbl[k].p));
            chk($sformatf("tbl%0d.lamp", k), int'(lamp), int'(tbl[k].l));
            chk($sformatf("tbl%0d.buzzer", k), int'(buzzer), int'(tbl[k].b));
            chk($sformatf("tbl%0d.escalate", k), int'(escalate), int'(tbl[k].e));
            chk($sformatf("tbl%0d.err", k), int'(err), int'(tbl[k].r));
        end

        // Escalation of ward 2 called at edge 1, then blinking.
        do_reset();
        step(1'b1, 3'd2, 4'h0);
        for (int e = 2; e <= 17; e++) begin
            step(1'b0, 3'd0, 4'h0);
            chk($sformatf("esc_early_e%0d", e), int'(escalate), 0);
        end
        for (int e = 18; e <= 30; e++) begin
            step(1'b0, 3'd0, 4'h0);
            check_model($sformatf("blink_e%0d", e));
            if (e == 18) begin
                chk("esc_e18.escalate", int'(escalate), 1);
                chk("esc_e18.lamp", int'(lamp), 0);
                chk("esc_e18.buzzer", int'(buzzer), 0);
            end
            if (e == 21) begin
                chk("esc_e21.lamp", int'(lamp), 4);
                chk("esc_e21.buzzer", int'(buzzer), 1);
            end
        end

        // Set and ack on the same ward in the same edge restarts the age.
        do_reset();
        step(1'b1, 3'd1, 4'h0);
        for (int e = 2; e <= 10; e++) step(1'b0, 3'd0, 4'h0);
        step(1'b1, 3'd1, 4'b0010);
        chk("setack.pending", int'(pending), 2);
        for (int e = 12; e <= 27; e++) begin
            step(1'b0, 3'd0, 4'h0);
            chk($sformatf("setack_early_e%0d", e), int'(escalate), 0);
        end
        step(1'b0, 3'd0, 4'h0);
        chk("setack_e28.escalate", int'(escalate), 1);

        // Wards 3 and 0, ward 3 escalates first, then both acknowledged.
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            if (e == 1) step(1'b1, 3'd3, 4'h0);
            else if (e == 5) step(1'b1, 3'd0, 4'h0);
            else if (e == 19) step(1'b0, 3'd0, 4'h8);
            else if (e == 20) step(1'b0, 3'd0, 4'h1);
            else step(1'b0, 3'd0, 4'h0);
            check_model($sformatf("two_e%0d", e));
            if (e == 18) chk("two_e18.escalate", int'(escalate), 1);
            if (e == 20) begin
                chk("two_e20.escalate", int'(escalate), 0);
                chk("two_e20.buzzer", int'(buzzer), 1);
            end
            if (e == 22) chk("two_e22.lamp", int'(lamp), 0);
`ifdef WARD_CALL_DECODER_SERVE_EN
            if (e == 18) chk("two_e18.serve_idx", int'(serve_idx), 3);
            if (e == 20) chk("two_e20.serve_idx", int'(serve_idx), 0);
            if (e == 21) chk("two_e21.serve_idx", int'(serve_idx), 4);
`endif
        end

        // Asynchronous reset mid-cycle with two calls pending.
        do_reset();
        step(1'b1, 3'd0, 4'h0);
        step(1'b1, 3'd2, 4'h0);
        step(1'b0, 3'd0, 4'h0);
        step(1'b0, 3'd0, 4'h0);
        chk("pre_async.lamp", int'(lamp), 5);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 3'd0, 4'h0);
            check_model($sformatf("post_rst_e%0d", e));
            chk($sformatf("post_rst_e%0d.lamp0", e), int'(lamp), 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit         v;
            logic [2:0] c;
            logic [3:0] a;
            v = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            for (int i = 0; i < 4; i++) a[i] = ($urandom_range(0, 23) == 0);
            step(v, c, a);
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ward_call_decoder
`default_nettype wire
